// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_lwhb;
  logic [1:0]  req_swhb;
  logic        req_lu;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lwhb, req_swhb, req_lu, req_pc,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lwhb, req_swhb, req_lu, req_pc,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable latency, byte/half/word access.
// Define DMEM_TRACE_EN to print a line for every committed store and every erroring access.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  lwhb;
    logic [1:0]  swhb;
    logic        lu;
    logic [31:0] pc;
  } req_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  req_t        req_q, req_d;

  logic [31:0] mem [DEPTH];

  logic [1:0]  acc_size;
  logic        acc_err;
  logic        exec;
  logic        mem_we;
  logic [AW-1:0] idx;
  logic [31:0] rword;
  logic [31:0] ld_sh;
  logic [31:0] ld_ext;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] wr_word;

  // Access decode on the captured request; size code 11 behaves as word.
  always_comb begin
    acc_size = req_q.we ? req_q.swhb : req_q.lwhb;
    acc_err  = ({2'b00, req_q.addr[31:2]} >= 32'(DEPTH));
    if (acc_size == 2'b01 && req_q.addr[0])
      acc_err = 1'b1;
    if ((acc_size == 2'b00 || acc_size == 2'b11) && req_q.addr[1:0] != 2'b00)
      acc_err = 1'b1;
    exec   = (state_q == WAIT) && (cnt_q == 4'd0);
    mem_we = exec && req_q.we && !acc_err;
    idx    = req_q.addr[AW+1:2];
    rword  = mem[idx];
  end

  always_comb begin
    ld_sh  = rword >> {req_q.addr[1:0], 3'b000};
    ld_ext = rword;
    case (req_q.lwhb)
      2'b10:   ld_ext = req_q.lu ? {24'b0, ld_sh[7:0]}  : {{24{ld_sh[7]}},  ld_sh[7:0]};
      2'b01:   ld_ext = req_q.lu ? {16'b0, ld_sh[15:0]} : {{16{ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = rword;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the target lanes.
  always_comb begin
    be = 4'b1111;
    wd = req_q.wdata;
    case (req_q.swhb)
      2'b10: begin
        be = 4'b0001 << req_q.addr[1:0];
        wd = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_q.wdata[15:0]}};
      end
      default: ;
    endcase
    wr_word = rword;
    for (int i = 0; i < 4; i++)
      if (be[i]) wr_word[8*i +: 8] = wd[8*i +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata,
                    lwhb: bus.req_lwhb, swhb: bus.req_swhb, lu: bus.req_lu, pc: bus.req_pc};
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = (!req_q.we && !acc_err) ? ld_ext : 32'd0;
          err_d   = acc_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Captured request and the array itself are never reset.
  always_ff @(posedge clk) begin
    req_q <= req_d;
    if (mem_we) mem[idx] <= wr_word;
`ifdef DMEM_TRACE_EN
    if (exec && acc_err)
      $display("pc = %h: DMEM ERR addr = %h", req_q.pc, req_q.addr);
    else if (mem_we)
      $display("pc = %h: dataaddr = %h, memdata = %h", req_q.pc, req_q.addr, wr_word);
`endif
  end

`ifndef DMEM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^req_q.pc;
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=1 instance for data paths and a LATENCY=4 instance for reset abort.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst4;
  logic        t_valid1, t_valid4, t_we, t_lu, t_rr;
  logic [31:0] t_addr, t_wdata, t_pc;
  logic [1:0]  t_lwhb, t_swhb;

  dmem_responder_if if1();
  dmem_responder_if if4();

  assign if1.req_valid = t_valid1;
  assign if1.req_we    = t_we;
  assign if1.req_addr  = t_addr;
  assign if1.req_wdata = t_wdata;
  assign if1.req_lwhb  = t_lwhb;
  assign if1.req_swhb  = t_swhb;
  assign if1.req_lu    = t_lu;
  assign if1.req_pc    = t_pc;
  assign if1.resp_ready = t_rr;

  assign if4.req_valid = t_valid4;
  assign if4.req_we    = t_we;
  assign if4.req_addr  = t_addr;
  assign if4.req_wdata = t_wdata;
  assign if4.req_lwhb  = t_lwhb;
  assign if4.req_swhb  = t_swhb;
  assign if4.req_lu    = t_lu;
  assign if4.req_pc    = t_pc;
  assign if4.resp_ready = t_rr;

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));
  dmem_responder #(.DEPTH(1024), .LATENCY(4)) dut4 (.clk(clk), .reset(rst4), .bus(if4.slave));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  function automatic logic rv(input bit s);
    return s ? if4.resp_valid : if1.resp_valid;
  endfunction
  function automatic logic rdy(input bit s);
    return s ? if4.req_ready : if1.req_ready;
  endfunction
  function automatic logic [31:0] rdat(input bit s);
    return s ? if4.resp_rdata : if1.resp_rdata;
  endfunction
  function automatic logic rerr(input bit s);
    return s ? if4.resp_err : if1.resp_err;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: drive, accept, wait for response, compare against scoreboard, hand back.
  task automatic xact(input bit s, input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] sz, input logic lu,
                      input logic [31:0] exp_rd, input logic exp_err, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    t_we    = we;
    t_addr  = addr;
    t_wdata = wdata;
    t_lwhb  = we ? 2'b10 : sz;
    t_swhb  = we ? sz : 2'b10;
    t_lu    = lu;
    t_pc    = 32'h0000_1000 + addr;
    t_rr    = (hold == 0);
    check({tag, " req_ready"}, 32'(rdy(s)), 32'd1);
    if (s) t_valid4 = 1'b1; else t_valid1 = 1'b1;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    t_valid1 = 1'b0;
    t_valid4 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rv(s) && n < 40);
    check({tag, " latency"}, 32'(n), s ? 32'd5 : 32'd2);
    e = sb.pop_front();
    check({tag, " rdata"}, rdat(s), e.rdata);
    check({tag, " err"}, 32'(rerr(s)), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 32'(rv(s)), 32'd1);
      check({tag, " hold rdata"}, rdat(s), e.rdata);
      check({tag, " hold ready"}, 32'(rdy(s)), 32'd0);
    end
    t_rr = 1'b1;
    @(negedge clk);
    check({tag, " post valid"}, 32'(rv(s)), 32'd0);
    check({tag, " post ready"}, 32'(rdy(s)), 32'd1);
    check({tag, " post rdata"}, rdat(s), 32'd0);
    check({tag, " post err"}, 32'(rerr(s)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_valid1 = 1'b0; t_valid4 = 1'b0; t_we = 1'b0; t_lu = 1'b0; t_rr = 1'b1;
    t_addr = '0; t_wdata = '0; t_pc = '0; t_lwhb = '0; t_swhb = '0;
    rst1 = 1'b1; rst4 = 1'b1;
    #1;
    check("rst req_ready", 32'(if1.req_ready), 32'd1);
    check("rst resp_valid", 32'(if1.resp_valid), 32'd0);
    check("rst resp_rdata", if1.resp_rdata, 32'd0);
    check("rst resp_err", 32'(if1.resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst1 = 1'b0; rst4 = 1'b0;

    xact(0, "st_w10",  1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0,        1'b0, 0);
    xact(0, "ld_w10",  1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEADBEEF, 1'b0, 0);

    xact(0, "st_w20",  1'b1, 32'h20, 32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 0);
    xact(0, "st_b22",  1'b1, 32'h22, 32'h00000080, 2'b10, 1'b0, 32'h0,        1'b0, 0);
    xact(0, "ld_w20",  1'b0, 32'h20, 32'h0,        2'b00, 1'b0, 32'h00800000, 1'b0, 0);
    xact(0, "ld_b22s", 1'b0, 32'h22, 32'h0,        2'b10, 1'b0, 32'hFFFFFF80, 1'b0, 0);
    xact(0, "ld_b22u", 1'b0, 32'h22, 32'h0,        2'b10, 1'b1, 32'h00000080, 1'b0, 0);

    xact(0, "st_w30",  1'b1, 32'h30, 32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 0);
    xact(0, "st_h32",  1'b1, 32'h32, 32'h00008001, 2'b01, 1'b0, 32'h0,        1'b0, 0);
    xact(0, "ld_h32s", 1'b0, 32'h32, 32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0, 0);
    xact(0, "ld_h31",  1'b0, 32'h31, 32'h0,        2'b01, 1'b0, 32'h0,        1'b1, 0);
    xact(0, "ld_w30",  1'b0, 32'h30, 32'h0,        2'b00, 1'b0, 32'h80010000, 1'b0, 0);

    xact(0, "ld_oor",  1'b0, 32'h1000, 32'h0,      2'b00, 1'b0, 32'h0,        1'b1, 0);
    xact(0, "st_w40",  1'b1, 32'h40, 32'h11111111, 2'b00, 1'b0, 32'h0,        1'b0, 0);
    xact(0, "st_w42",  1'b1, 32'h42, 32'hAAAAAAAA, 2'b00, 1'b0, 32'h0,        1'b1, 0);
    xact(0, "ld_w40",  1'b0, 32'h40, 32'h0,        2'b00, 1'b0, 32'h11111111, 1'b0, 0);

    xact(0, "ld_bp",   1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEADBEEF, 1'b0, 5);

    // Reset abort on the LATENCY=4 instance: the pending store must never land.
    xact(1, "st4_w50", 1'b1, 32'h50, 32'hCAFEF00D, 2'b00, 1'b0, 32'h0,        1'b0, 0);
    @(negedge clk);
    t_we = 1'b1; t_addr = 32'h50; t_wdata = 32'h12345678; t_lwhb = 2'b10; t_swhb = 2'b00; t_lu = 1'b0;
    t_valid4 = 1'b1;
    @(posedge clk);
    #1;
    t_valid4 = 1'b0;
    check("abort pre ready", 32'(if4.req_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst4 = 1'b1;
    #1;
    check("abort req_ready", 32'(if4.req_ready), 32'd1);
    check("abort resp_valid", 32'(if4.resp_valid), 32'd0);
    check("abort resp_rdata", if4.resp_rdata, 32'd0);
    check("abort resp_err", 32'(if4.resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    xact(1, "ld4_w50", 1'b0, 32'h50, 32'h0,        2'b00, 1'b0, 32'hCAFEF00D, 1'b0, 0);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
